full_adder_unit: RTL and testbench
==================================

// Module: full_adder_unit
// PURPOSE
//  Registered full-adder cell: sum/carry-out of a + b + cin, one-cycle latency.
//  WIDTH=1 (default) is the single-bit full adder used as the slice of the
//  ripple-carry adder/subtractor.
//  WIDTH>1 chains WIDTH slices internally (ripple) and registers the result.
//  Sits in the datapath between operand registers and result consumers.
// PARAMETERS
//  WIDTH   1  operand/sum width in bits (>=1); carry ripples LSB->MSB
// PORTS
//  clk        input   1      rising-edge clock
//  rst        input   1      reset, asynchronous, active-high
//  in_valid   input   1      operands valid this cycle
//  sub        input   1      0: a+b+cin; 1: a+~b+cin (two's-complement subtract)
//  a          input   WIDTH  operand A
//  b          input   WIDTH  operand B
//  cin        input   1      carry-in to bit 0
//  out_valid  output  1      sum/cout valid
//  sum        output  WIDTH  registered sum
//  cout       output  1      registered carry-out of MSB
//  ovf        output  1      registered signed overflow (carry into MSB ^ cout)
// BEHAVIOUR
//  - rst high (any time, async): sum=0, cout=0, ovf=0, out_valid=0 immediately;
//    held while rst high. First capture on first rising clk after rst drops.
//  - Slice function: s = a ^ b' ^ c; co = (a & b') | (c & (a ^ b')),
//    b' = b ^ sub; carry into bit 0 is cin (caller sets cin=1 for a-b).
//  - Bit i carry-in = carry-out of bit i-1; cout = carry-out of bit WIDTH-1.
//  - {cout,sum} == a + b' + cin exactly, computed at full WIDTH+1 precision;
//    no saturation, wrap-around modulo 2^WIDTH in sum.
//  - Latency 1: on clk edge with in_valid=1, register sum/cout/ovf from
//    current inputs, out_valid<=1. With in_valid=0: out_valid<=0, sum/cout/ovf
//    hold previous values.
//  - No backpressure; a new operand set accepted every cycle (throughput 1/clk).
//  - X/undriven inputs while in_valid=0 must not disturb held outputs.
//  - Purely feed-forward: no state machine beyond the output register.
// STRUCTURE
//  - Sub-module full_adder_bit (combinational: a,b,cin -> sum,cout), instanced
//    WIDTH times via generate; top adds sub-inversion, ovf, output register.
//  - Shared package: none required; WIDTH is the only constant.
// TESTING
//  - WIDTH=1, all 8 (a,b,cin) combos, sub=0 -> {cout,sum}=a+b+cin
//    (e.g. 1,1,1 -> cout=1,sum=1; 1,0,0 -> 0,1), one cycle later.
//  - WIDTH=8: a=00,b=00,cin=0 -> sum=00,cout=0; a=F0,b=F0 -> sum=E0,cout=1;
//    a=FF,b=FF -> sum=FE,cout=1; a=FF,b=00,cin=1 -> sum=00,cout=1.
//  - WIDTH=8 subtract: sub=1,cin=1, a=05,b=03 -> sum=02,cout=1;
//    a=03,b=05 -> sum=FE,cout=0; a=80,b=01 -> sum=7F,ovf=1.
//  - Back-to-back in_valid every cycle: outputs track inputs delayed 1 clk;
//    in_valid=0 -> out_valid=0, sum/cout held.
//  - Assert rst mid-stream between clk edges -> outputs 0 immediately,
//    out_valid=0; deassert -> next valid operands appear 1 clk later.
//  - Random WIDTH=8 compare vs. behavioural model (a + (b^{8{sub}}) + cin),
//    >=1000 vectors, zero mismatches.

Source files
------------

// File: rtl/full_adder_unit_pkg.sv
// Shared constants for the registered full-adder cell.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package full_adder_unit_pkg;

  // Single-bit slice is the common use as a ripple-carry building block.
  localparam int DEFAULT_WIDTH = 1;

endpackage : full_adder_unit_pkg

// File: rtl/full_adder_bit.sv
// Combinational one-bit full adder slice: sum/carry of a + b + cin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  // Half-sum is shared by the sum and the propagate term of the carry.
  assign half = a ^ b;
  assign sum  = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule : full_adder_bit

// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple adder/subtractor with carry-out and signed overflow.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; accepts a new operand set every clock, outputs hold when idle.
module full_adder_unit
  import full_adder_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Subtraction inverts B; the caller supplies cin=1 to complete two's complement.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign carry[0] = cin;

  // Carry ripples LSB to MSB through one slice per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .sum  (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf_c = carry[WIDTH-1] ^ carry[WIDTH];

  // Output register: capture on valid, otherwise hold results and drop valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_c;
        cout <= carry[WIDTH];
        ovf  <= ovf_c;
      end
    end
  end

endmodule : full_adder_unit

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH=1 and WIDTH=8.
// Latency: expects results one clock after operands are presented.
// Backpressure: none; operands are driven every cycle where required.
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic v1, s1, a1, b1, c1;
  logic ov1, sum1, co1, of1;

  // WIDTH=8 instance
  logic       v8, s8, c8;
  logic [7:0] a8, b8;
  logic       ov8, co8, of8;
  logic [7:0] sum8;

  int n_vec = 0;
  int n_bad = 0;

  // Expected WIDTH=8 output state: {cout, ovf, sum} and out_valid.
  logic [9:0] exp8;
  logic       expv8;

  full_adder_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .sub(s1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(sum1), .cout(co1), .ovf(of1)
  );

  full_adder_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .sub(s8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(sum8), .cout(co8), .ovf(of8)
  );

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
  function automatic logic [9:0] model8(input logic s, input logic [7:0] a,
                                        input logic [7:0] b, input logic c);
    logic [7:0] bb;
    int u;
    int sg;
    bb = s ? ~b : b;
    u  = int'(a) + int'(bb) + int'(c);
    sg = int'($signed(a)) + int'($signed(bb)) + int'(c);
    return {u[8], (sg > 127 || sg < -128), u[7:0]};
  endfunction

  // Present one operand set (or an idle cycle with X operands) and advance past the edge.
  task automatic drive8(input logic v, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input logic c);
    @(negedge clk);
    v8 = v;
    if (v) begin
      s8 = s; a8 = a; b8 = b; c8 = c;
    end else begin
      s8 = 1'bx; a8 = 'x; b8 = 'x; c8 = 1'bx;
    end
    @(posedge clk);
    #1;
    expv8 = v;
    if (v) exp8 = model8(s, a, b, c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v1 = 1'b1; s1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; s8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    #2;
    n_vec++;
    if ({ov8, co8, of8, sum8} !== 11'd0 || {ov1, co1, of1, sum1} !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_async: w8 got %b, w1 got %b, want all zero",
               {ov8, co8, of8, sum8}, {ov1, co1, of1, sum1});
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({ov8, co8, of8, sum8} !== 11'd0 || {ov1, co1, of1, sum1} !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_held: w8 got %b, w1 got %b, want all zero",
               {ov8, co8, of8, sum8}, {ov1, co1, of1, sum1});
    end
    @(negedge clk);
    rst = 1'b0;
    v1 = 1'b0;
    v8 = 1'b0;
    expv8 = 1'b0;
    exp8 = '0;
  endtask

  task automatic test_add1();
    int t;
    int sg;
    logic bb;
    logic ex_ovf;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v1 = 1'b1; a1 = i[2]; b1 = i[1]; c1 = i[0]; s1 = i[3];
      bb = b1 ^ s1;
      t  = int'(a1) + int'(bb) + int'(c1);
      sg = -int'(a1) - int'(bb) + int'(c1);
      ex_ovf = (sg < -1 || sg > 0);
      @(posedge clk);
      #1;
      n_vec++;
      if ({ov1, co1, of1, sum1} !== {1'b1, t[1], ex_ovf, t[0]}) begin
        n_bad++;
        $display("FAIL add1[%0d]: got v/co/ovf/sum=%b, want %b", i,
                 {ov1, co1, of1, sum1}, {1'b1, t[1], ex_ovf, t[0]});
      end
    end
    // Last vector was sub=1, a=1, b=1, cin=1: 1 + 0 + 1 -> cout=1, sum=0, ovf=0.
    @(negedge clk);
    v1 = 1'b0; a1 = 1'bx; b1 = 1'bx; c1 = 1'bx; s1 = 1'bx;
    @(posedge clk);
    #1;
    n_vec++;
    if ({ov1, co1, of1, sum1} !== 4'b0100) begin
      n_bad++;
      $display("FAIL add1_hold: got %b, want 0100", {ov1, co1, of1, sum1});
    end
  endtask

  task automatic test_directed8();
    // {sub, a, b, cin, sum, cout, ovf}
    logic [27:0] vec [9] = '{
      {1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      {1'b0, 8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1, 1'b0},
      {1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0},
      {1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
      {1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0},
      {1'b1, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0},
      {1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1},
      {1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      {1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1}
    };
    logic [27:0] e;
    for (int i = 0; i < 9; i++) begin
      e = vec[i];
      drive8(1'b1, e[27], e[26:19], e[18:11], e[10]);
      n_vec++;
      if ({ov8, co8, of8, sum8} !== {1'b1, e[1], e[0], e[9:2]}) begin
        n_bad++;
        $display("FAIL dir8[%0d]: got v=%b co=%b ovf=%b sum=%h, want co=%b ovf=%b sum=%h",
                 i, ov8, co8, of8, sum8, e[1], e[0], e[9:2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      if (i >= 16 && i < 20) drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      else drive8(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      n_vec++;
      if ({ov8, co8, of8, sum8} !== {expv8, exp8}) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got v/co/ovf/sum=%b_%h, want %b_%h", i,
                 {ov8, co8, of8}, sum8, {expv8, exp8[9:8]}, exp8[7:0]);
      end
    end
  endtask

  task automatic test_rst_midstream();
    drive8(1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
    n_vec++;
    if ({ov8, co8, of8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h46}) begin
      n_bad++;
      $display("FAIL mid_pre: got %b_%h, want 100_46", {ov8, co8, of8}, sum8);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ov8, co8, of8, sum8} !== 11'd0) begin
      n_bad++;
      $display("FAIL mid_async: got %b_%h, want 000_00", {ov8, co8, of8}, sum8);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({ov8, co8, of8, sum8} !== 11'd0) begin
      n_bad++;
      $display("FAIL mid_held: got %b_%h, want 000_00", {ov8, co8, of8}, sum8);
    end
    @(negedge clk);
    rst = 1'b0;
    v8 = 1'b1; s8 = 1'b1; a8 = 8'h10; b8 = 8'h01; c8 = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({ov8, co8, of8, sum8} !== {1'b1, 1'b1, 1'b0, 8'h0F}) begin
      n_bad++;
      $display("FAIL mid_post: got %b_%h, want 110_0f", {ov8, co8, of8}, sum8);
    end
    expv8 = 1'b1;
    exp8  = {1'b1, 1'b0, 8'h0F};
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      drive8($urandom_range(0, 7) != 0, 1'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom));
      n_vec++;
      if ({ov8, co8, of8, sum8} !== {expv8, exp8}) begin
        n_bad++;
        $display("FAIL rand[%0d]: got v/co/ovf/sum=%b_%h, want %b_%h", i,
                 {ov8, co8, of8}, sum8, {expv8, exp8[9:8]}, exp8[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add1();
    test_directed8();
    test_back_to_back();
    test_rst_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_full_adder_unit
